banded_multi_solver: RTL and testbench
======================================

# banded_multi_solver

Parametrised array of `pattern_solver` instances that splits one complex-plane region into `NUM_SOLVERS` horizontal bands, runs all bands concurrently and stores each band's output stream in its own RAM bank. It adds a start/busy/done job handshake, per-bank word counts with sticky overflow, and a registered read port with a valid strobe. It sits between the region-setup logic and the frame readout/display path.

## Interface
- `NUM_SOLVERS`, 4: number of solver/bank pairs; legal range 1..64.
- `COORD_W`, 27: signed coordinate width.
- `DATA_W`, 8: solver output word width.
- `ADDR_W`, 10: bank address width; bank depth is 2^ADDR_W.
- `ID_W`, 6: width of the solver-select field.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: reset, synchronous and active-high.
- `start` in 1: single-cycle job start pulse.
- `min_x`, `min_y`, `max_x`, `max_y` in COORD_W each, signed: region bounds.
- `dx`, `dy` in COORD_W each, signed: pixel step.
- `band_step` in COORD_W, signed: y height of one band.
- `busy` out 1: job in progress.
- `done` out 1: all bands finished; held until the next `start` or `reset`.
- `overflow` out NUM_SOLVERS: sticky per-bank overflow flags.
- `rd_en` in 1: read request.
- `rd_solver_id` in ID_W: bank select.
- `rd_addr` in ADDR_W: word address.
- `rd_data` out DATA_W, signed: read data.
- `rd_count` out ADDR_W+1: number of words the selected bank holds.
- `rd_valid` out 1: `rd_data` and `rd_count` are valid.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset value is IDLE.
- `start` in any state goes to LOAD. A `start` during RUN aborts the current job. `reset` has priority over `start`.
- LOAD lasts one cycle:
  - Latch all bounds.
  - Band i gets `min_y_i = min_y + i*band_step` and `max_y_i = min_y_i + band_step - dy`.
  - The last band uses `max_y_i = max_y`.
  - x bounds, `dx` and `dy` are shared by all bands.
  - Per-bank counts and `overflow` clear to 0.
  - Solver local reset is `reset | (state==LOAD)`.
- In RUN, for each solver i:
  - `continue_i = solver_ready_i & ~solver_done_i`.
  - On `solver_ready_i`, if `count_i < 2^ADDR_W`: write `solver_out_i` to bank i at address `count_i`, then increment `count_i`.
  - If `count_i == 2^ADDR_W`: drop the write and set `overflow[i]`. The solver is still continued so that it terminates.
- RUN goes to DONE in the cycle after all `solver_done` bits are high together.
- DONE is held until the next `start`.
- `busy = (state==LOAD || state==RUN)`. `done = (state==DONE)`.
- Reads are legal in any state. Reading a bank that is being written returns either the old or the new word. That case is not checked.
- If `rd_solver_id >= NUM_SOLVERS`, `rd_data` is 0 and `rd_count` is 0, and `rd_valid` still pulses.
- Arithmetic:
  - `i*band_step` is computed at full COORD_W, two's-complement, with wraparound. No saturation.
  - Counts are ADDR_W+1 bits and never exceed 2^ADDR_W.

## Timing
- Reset values: `busy`=0, `done`=0, `overflow`=0, `rd_valid`=0, `rd_data`=0, `rd_count`=0, all counts 0.
- `start` at cycle t: LOAD at t+1, with `busy` high from t+1. RUN from t+2, when solvers leave reset.
- Last solver done at cycle t: `done` high and `busy` low at t+1.
- Read latency is one cycle. `rd_en` at t gives `rd_data`, `rd_count` and `rd_valid` at t+1.
- `rd_valid` is low in any cycle after one with no `rd_en`. `rd_data` holds its last value when `rd_en` is low.
- Back-to-back reads are accepted every cycle.
- A bank write and a read of the same bank in the same cycle both proceed. The two ports are independent.

## Structure
- The shared package holds:
  - the FSM state encoding (IDLE/LOAD/RUN/DONE);
  - default widths `COORD_W`, `DATA_W`, `ADDR_W`, `ID_W`.
- Sub-module `solver_bank_ram`: simple dual-port RAM, parametrised by `DATA_W`/`ADDR_W`, one write port, one registered read port with `rd_en`.
- Top level contains:
  - a generate loop of `pattern_solver` + `solver_bank_ram` + count/overflow logic per band;
  - the FSM;
  - the output read mux with its registers.

## Test plan
- After `reset`, drive nothing for 5 cycles. Required: all outputs at their reset values and `busy`=0.
- `NUM_SOLVERS`=2, `min_y`=0, `band_step`=64, `dy`=1, `max_y`=127. Required: band 0 gets y 0..63, band 1 gets y 64..127; each bank's `rd_count` equals its solver's ready count; `done` is high exactly one cycle after the last solver done.
- `ADDR_W`=4, with a band yielding more than 16 words. Required: `rd_count`=16, `overflow[i]`=1, words 0..15 match the first 16 solver outputs, and `done` still asserts.
- Pulse `start` mid-RUN. Required: `busy` stays 1, counts return to 0 at LOAD, and bank contents come from the new job only.
- `rd_en` with id 1, address 3, then id 7 (out of range), on consecutive cycles. Required: the correct word at t+1, then 0 at t+2, with `rd_valid` high at both.
- `reset` and `start` asserted in the same cycle. Required: state IDLE and `busy`=0 the next cycle.

Source files
------------

// File: rtl/banded_multi_solver_pkg.sv
// Shared definitions for the banded solver array.
//   state_e        : job FSM encoding (idle, load, run, done)
//   Default*       : default widths used by the top level and its interface
package banded_multi_solver_pkg;

  localparam int unsigned DefaultCoordW = 27;
  localparam int unsigned DefaultDataW  = 8;
  localparam int unsigned DefaultAddrW  = 10;
  localparam int unsigned DefaultIdW    = 6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/banded_multi_solver_if.sv
// Job and readout bus of banded_multi_solver.
//   job  : start, min_x/min_y/max_x/max_y, dx/dy, band_step -> busy, done, overflow
//   read : rd_en, rd_solver_id, rd_addr -> rd_data, rd_count, rd_valid
// master = region-setup / readout side, slave = the solver array.
interface banded_multi_solver_if #(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned COORD_W     = banded_multi_solver_pkg::DefaultCoordW,
  parameter int unsigned DATA_W      = banded_multi_solver_pkg::DefaultDataW,
  parameter int unsigned ADDR_W      = banded_multi_solver_pkg::DefaultAddrW,
  parameter int unsigned ID_W        = banded_multi_solver_pkg::DefaultIdW
);

  logic                      start;
  logic signed [COORD_W-1:0] min_x;
  logic signed [COORD_W-1:0] min_y;
  logic signed [COORD_W-1:0] max_x;
  logic signed [COORD_W-1:0] max_y;
  logic signed [COORD_W-1:0] dx;
  logic signed [COORD_W-1:0] dy;
  logic signed [COORD_W-1:0] band_step;
  logic                      busy;
  logic                      done;
  logic [NUM_SOLVERS-1:0]    overflow;
  logic                      rd_en;
  logic [ID_W-1:0]           rd_solver_id;
  logic [ADDR_W-1:0]         rd_addr;
  logic signed [DATA_W-1:0]  rd_data;
  logic [ADDR_W:0]           rd_count;
  logic                      rd_valid;

  modport master (
    output start, min_x, min_y, max_x, max_y, dx, dy, band_step,
    output rd_en, rd_solver_id, rd_addr,
    input  busy, done, overflow, rd_data, rd_count, rd_valid
  );

  modport slave (
    input  start, min_x, min_y, max_x, max_y, dx, dy, band_step,
    input  rd_en, rd_solver_id, rd_addr,
    output busy, done, overflow, rd_data, rd_count, rd_valid
  );

endinterface

// File: rtl/pattern_solver.sv
// Raster-scanning pattern solver for one rectangular region.
//   clock, reset      : clock and synchronous active-high reset (reset loads the bounds)
//   resume            : accept the presented word and advance to the next pixel
//   min_*/max_*/dx/dy : region bounds and step, sampled while reset is high
//   out, ready        : word for the current pixel, valid while ready is high
//   done              : whole region emitted
// Pixels are visited x-fastest; the word is the low bits of x ^ y.
module pattern_solver #(
  parameter int unsigned COORD_W = 27,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      resume,
  input  logic signed [COORD_W-1:0] min_x,
  input  logic signed [COORD_W-1:0] min_y,
  input  logic signed [COORD_W-1:0] max_x,
  input  logic signed [COORD_W-1:0] max_y,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  output logic signed [DATA_W-1:0]  out,
  output logic                      ready,
  output logic                      done
);

  logic signed [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic                      done_q, done_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    done_d = done_q;
    if (resume && !done_q) begin
      if (x_q + dx > max_x) begin
        x_d = min_x;
        if (y_q + dy > max_y) begin
          done_d = 1'b1;
        end else begin
          y_d = y_q + dy;
        end
      end else begin
        x_d = x_q + dx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= min_x;
      y_q    <= min_y;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

  assign out   = DATA_W'(x_q ^ y_q);
  assign ready = ~done_q;
  assign done  = done_q;

endmodule

// File: rtl/solver_bank_ram.sv
// Simple dual-port RAM holding one band's output stream.
//   clock                     : clock
//   wr_en, wr_addr, wr_data   : write port
//   rd_en, rd_addr, rd_data   : registered read port, rd_data holds while rd_en is low
module solver_bank_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/banded_multi_solver.sv
// Splits a region into NUM_SOLVERS horizontal bands solved concurrently, one RAM bank per band.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : start/busy/done job handshake, region bounds, sticky per-bank overflow,
//                  and a one-cycle-latency read port (rd_data, rd_count, rd_valid)
module banded_multi_solver
  import banded_multi_solver_pkg::*;
#(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned COORD_W     = DefaultCoordW,
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned ID_W        = DefaultIdW
) (
  input logic                  clock,
  input logic                  reset,
  banded_multi_solver_if.slave bus
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  state_e state_q, state_d;
  logic   load, run, busy, done;
  logic   solver_reset;

  logic signed [COORD_W-1:0] min_x_q, min_y_q, max_x_q, max_y_q, dx_q, dy_q, band_step_q;

  logic [NUM_SOLVERS-1:0] solver_done;
  logic [NUM_SOLVERS-1:0] ovf;
  logic [ADDR_W:0]        count_arr  [NUM_SOLVERS];
  logic [DATA_W-1:0]      bank_rdata [NUM_SOLVERS];

  // Bounds are captured on the start edge so they are already stable during LOAD,
  // which is when the solvers sit in reset and sample their band bounds.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_x_q     <= '0;
      min_y_q     <= '0;
      max_x_q     <= '0;
      max_y_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      band_step_q <= '0;
    end else if (bus.start) begin
      min_x_q     <= bus.min_x;
      min_y_q     <= bus.min_y;
      max_x_q     <= bus.max_x;
      max_y_q     <= bus.max_y;
      dx_q        <= bus.dx;
      dy_q        <= bus.dy;
      band_step_q <= bus.band_step;
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; start restarts from any state, aborting a running job
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StLoad: state_d = StRun;
        StRun:  if (&solver_done) state_d = StDone;
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    load = (state_q == StLoad);
    run  = (state_q == StRun);
    busy = load | run;
    done = (state_q == StDone);
  end

  assign solver_reset = reset | load;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = ovf;

  for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_band
    localparam logic signed [COORD_W-1:0] BandIdx = COORD_W'(i);

    logic signed [COORD_W-1:0] band_min_y, band_max_y;
    logic signed [DATA_W-1:0]  solver_out;
    logic                      solver_ready;
    logic                      resume, wr_en;
    logic [ADDR_W:0]           count_q;
    logic                      ovf_q;

    // Product truncates to COORD_W, i.e. two's-complement wraparound.
    assign band_min_y = min_y_q + BandIdx * band_step_q;

    if (i == NUM_SOLVERS - 1) begin : g_last
      assign band_max_y = max_y_q;
    end else begin : g_mid
      assign band_max_y = band_min_y + band_step_q - dy_q;
    end

    // A full bank still lets its solver run to completion; only the write is dropped.
    assign resume = run & solver_ready & ~solver_done[i];
    assign wr_en  = run & solver_ready & (count_q != Depth);

    pattern_solver #(
      .COORD_W(COORD_W),
      .DATA_W (DATA_W)
    ) u_solver (
      .clock (clock),
      .reset (solver_reset),
      .resume(resume),
      .min_x (min_x_q),
      .min_y (band_min_y),
      .max_x (max_x_q),
      .max_y (band_max_y),
      .dx    (dx_q),
      .dy    (dy_q),
      .out   (solver_out),
      .ready (solver_ready),
      .done  (solver_done[i])
    );

    solver_bank_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_ram (
      .clock  (clock),
      .wr_en  (wr_en),
      .wr_addr(count_q[ADDR_W-1:0]),
      .wr_data(solver_out),
      .rd_en  (bus.rd_en),
      .rd_addr(bus.rd_addr),
      .rd_data(bank_rdata[i])
    );

    always_ff @(posedge clock) begin
      if (reset || load) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (run && solver_ready) begin
        if (count_q == Depth) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + (ADDR_W + 1)'(1);
        end
      end
    end

    assign count_arr[i] = count_q;
    assign ovf[i]       = ovf_q;
  end

  // Read mux. Banks are read unconditionally on rd_en; the bank select is registered
  // alongside so rd_data tracks the bank outputs and holds while rd_en is low.
  logic              rd_hit_d, rd_hit_q, rd_valid_q;
  logic [ADDR_W:0]   rd_count_d, rd_count_q;
  logic [ID_W-1:0]   rd_sel_q;
  logic [DATA_W-1:0] rd_data_sel;

  always_comb begin
    rd_hit_d   = 1'b0;
    rd_count_d = '0;
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      if (bus.rd_solver_id == ID_W'(i)) begin
        rd_hit_d   = 1'b1;
        rd_count_d = count_arr[i];
      end
    end
  end

  always_comb begin
    rd_data_sel = '0;
    for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
      if (rd_sel_q == ID_W'(i)) begin
        rd_data_sel = bank_rdata[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_sel_q   <= '0;
      rd_count_q <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_hit_q   <= rd_hit_d;
        rd_sel_q   <= bus.rd_solver_id;
        rd_count_q <= rd_count_d;
      end
    end
  end

  assign bus.rd_data  = rd_hit_q ? $signed(rd_data_sel) : '0;
  assign bus.rd_count = rd_count_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_banded_multi_solver.sv
module tb_banded_multi_solver;

  localparam int unsigned NumSolvers = 2;
  localparam int unsigned CoordW     = 27;
  localparam int unsigned DataW      = 8;
  localparam int unsigned AddrW      = 4;
  localparam int unsigned IdW        = 6;

  typedef struct {
    int min_x; int max_x; int dx;
    int min_y; int max_y; int dy; int band_step;
    int lat;   int cnt0;  int cnt1; int ovf;
  } job_t;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  banded_multi_solver_if #(
    .NUM_SOLVERS(NumSolvers), .COORD_W(CoordW), .DATA_W(DataW), .ADDR_W(AddrW), .ID_W(IdW)
  ) bus ();

  banded_multi_solver #(
    .NUM_SOLVERS(NumSolvers), .COORD_W(CoordW), .DATA_W(DataW), .ADDR_W(AddrW), .ID_W(IdW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input int id, input int addr);
    bus.rd_en        = 1'b1;
    bus.rd_solver_id = IdW'(id);
    bus.rd_addr      = AddrW'(addr);
    step();
    bus.rd_en = 1'b0;
  endtask

  function automatic int data_now();
    logic [DataW-1:0] d;
    d = bus.rd_data;
    return int'(d);
  endfunction

  // Word k of band b: raster order x-fastest, value = low byte of x ^ y.
  function automatic int exp_word(input job_t j, input int b, input int k);
    int nx, x, y;
    nx = (j.max_x - j.min_x) / j.dx + 1;
    x  = j.min_x + (k % nx) * j.dx;
    y  = j.min_y + b * j.band_step + (k / nx) * j.dy;
    return (x ^ y) & 8'hff;
  endfunction

  // Applies the job and returns with start already sampled (FSM in LOAD).
  task automatic start_job(input job_t j);
    bus.min_x     = CoordW'(j.min_x);
    bus.max_x     = CoordW'(j.max_x);
    bus.dx        = CoordW'(j.dx);
    bus.min_y     = CoordW'(j.min_y);
    bus.max_y     = CoordW'(j.max_y);
    bus.dy        = CoordW'(j.dy);
    bus.band_step = CoordW'(j.band_step);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 500) begin
      step();
      cycles++;
    end
  endtask

  task automatic check_job(input string tag, input job_t j);
    int cnt;
    rd(0, 0);
    check({tag, " rd_valid"}, int'(bus.rd_valid), 1);
    check({tag, " count0"}, int'(bus.rd_count), j.cnt0);
    rd(1, 0);
    check({tag, " count1"}, int'(bus.rd_count), j.cnt1);
    check({tag, " overflow"}, int'(bus.overflow), j.ovf);
    for (int b = 0; b < 2; b++) begin
      cnt = (b == 0) ? j.cnt0 : j.cnt1;
      for (int k = 0; k < cnt; k++) begin
        rd(b, k);
        check($sformatf("%s bank%0d word%0d", tag, b, k), data_now(), exp_word(j, b, k));
      end
    end
  endtask

  job_t jobs [3];
  job_t abort_job;
  int   cyc;

  initial begin
    // band 0 y 0..48 / band 1 y 64..112 step 16, two columns: 8 words each
    jobs[0] = '{min_x: 0, max_x: 1, dx: 1, min_y: 0, max_y: 127, dy: 16, band_step: 64,
                lat: 10, cnt0: 8, cnt1: 8, ovf: 0};
    // last band stretches to max_y: 4 words then 6 words
    jobs[1] = '{min_x: 0, max_x: 0, dx: 1, min_y: 0, max_y: 9, dy: 1, band_step: 4,
                lat: 8, cnt0: 4, cnt1: 6, ovf: 0};
    // 64 words per band into 16-deep banks
    jobs[2] = '{min_x: 0, max_x: 0, dx: 1, min_y: 0, max_y: 127, dy: 1, band_step: 64,
                lat: 66, cnt0: 16, cnt1: 16, ovf: 3};
    abort_job       = jobs[1];
    abort_job.min_x = 5;
    abort_job.max_x = 5;

    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.min_x        = '0;
    bus.min_y        = '0;
    bus.max_x        = '0;
    bus.max_y        = '0;
    bus.dx           = '0;
    bus.dy           = '0;
    bus.band_step    = '0;
    bus.rd_en        = 1'b0;
    bus.rd_solver_id = '0;
    bus.rd_addr      = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset overflow", int'(bus.overflow), 0);
    check("reset rd_valid", int'(bus.rd_valid), 0);
    check("reset rd_data", data_now(), 0);
    check("reset rd_count", int'(bus.rd_count), 0);

    // start at t -> busy at t+1; done exactly lat cycles after the LOAD edge
    for (int n = 0; n < 3; n++) begin
      start_job(jobs[n]);
      check($sformatf("job%0d busy_at_load", n), int'(bus.busy), 1);
      check($sformatf("job%0d done_at_load", n), int'(bus.done), 0);
      wait_done(cyc);
      check($sformatf("job%0d done_latency", n), cyc, jobs[n].lat);
      check($sformatf("job%0d busy_at_done", n), int'(bus.busy), 0);
      check_job($sformatf("job%0d", n), jobs[n]);
      check($sformatf("job%0d done_held", n), int'(bus.done), 1);
    end

    // back-to-back: id 1 addr 3, id 7 (out of range), id 1 addr 3, then idle
    bus.rd_en        = 1'b1;
    bus.rd_solver_id = IdW'(1);
    bus.rd_addr      = AddrW'(3);
    step();
    check("b2b valid1", int'(bus.rd_valid), 1);
    check("b2b data1", data_now(), exp_word(jobs[2], 1, 3));
    check("b2b count1", int'(bus.rd_count), 16);
    bus.rd_solver_id = IdW'(7);
    step();
    check("b2b valid7", int'(bus.rd_valid), 1);
    check("b2b data7", data_now(), 0);
    check("b2b count7", int'(bus.rd_count), 0);
    bus.rd_solver_id = IdW'(1);
    step();
    check("b2b data1_again", data_now(), exp_word(jobs[2], 1, 3));
    bus.rd_en = 1'b0;
    step();
    check("idle valid", int'(bus.rd_valid), 0);
    check("idle data_hold", data_now(), exp_word(jobs[2], 1, 3));

    // abort: let the overflow job fill bank 0, then restart with a different job
    start_job(jobs[2]);
    repeat (25) step();
    check("abort pre overflow", int'(bus.overflow), 3);
    start_job(abort_job);
    check("abort busy_load", int'(bus.busy), 1);
    step();
    check("abort busy_run", int'(bus.busy), 1);
    rd(0, 0);
    check("abort count_cleared", int'(bus.rd_count), 0);
    check("abort overflow_cleared", int'(bus.overflow), 0);
    wait_done(cyc);
    check("abort done_seen", int'(bus.done), 1);
    check_job("abort", abort_job);

    // reset wins over start
    reset     = 1'b1;
    bus.start = 1'b1;
    step();
    check("rst+start busy", int'(bus.busy), 0);
    check("rst+start done", int'(bus.done), 0);
    reset     = 1'b0;
    bus.start = 1'b0;
    step();
    check("rst+start idle busy", int'(bus.busy), 0);
    check("rst+start idle done", int'(bus.done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
